// File: rtl/sha_2_message_schedule.sv
`default_nettype none
// ============================================================================
// Module   : sha_2_message_schedule
// Purpose  : SHA-256 message schedule generator. It takes in the 16 words of
//            one 512-bit block as a valid/ready stream and passes them on as
//            W[0..15]. It then expands W[16..63] from a 16-word sliding window
//            and emits one word, with its index, per output handshake.
// Ports    : clk             - clock, rising edge
//            nrst            - asynchronous active-low reset
//            data_in         - message word M[t], t = 0..15
//            data_in_valid   - data_in holds a valid word
//            data_in_ready   - block accepts data_in this cycle
//            data_out        - schedule word W[t]
//            data_out_id     - index t of data_out (0..63)
//            data_out_last   - high together with W[63]
//            data_out_valid  - data_out / data_out_id / data_out_last valid
//            data_out_ready  - downstream accepts data_out this cycle
// Revision : 1.0 - initial release
// ============================================================================
module sha_2_message_schedule #(
  parameter int DATA_WIDTH = 32  // only 32 (SHA-256) is meaningful
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [5:0]            data_out_id,
  output logic                  data_out_last,
  output logic                  data_out_valid,
  input  logic                  data_out_ready
);

  typedef enum logic [0:0] {
    ST_LOAD   = 1'b0,
    ST_EXPAND = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [5:0]            t_q, t_d;
  logic [DATA_WIDTH-1:0] win_q [16];
  logic [DATA_WIDTH-1:0] win_d [16];
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic [5:0]            id_q, id_d;
  logic                  last_q, last_d;
  logic                  valid_q, valid_d;

  logic                  out_free;
  logic                  in_hs;
  logic                  shift_en;
  logic [DATA_WIDTH-1:0] shift_word;
  logic [DATA_WIDTH-1:0] expand_word;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    rotr = (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    ssig0 = rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    ssig1 = rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // win[0] = W[t-16], win[1] = W[t-15], win[9] = W[t-7], win[14] = W[t-2]
  assign expand_word = ssig1(win_q[14]) + win_q[9] + ssig0(win_q[1]) + win_q[0];

  // The output register may be reloaded when it is empty or drains this cycle.
  assign out_free      = !valid_q || data_out_ready;
  assign data_in_ready = (state_q == ST_LOAD) && out_free;
  assign in_hs         = data_in_valid && data_in_ready;

  always_comb begin
    state_d    = state_q;
    t_d        = t_q;
    out_d      = out_q;
    id_d       = id_q;
    last_d     = last_q;
    valid_d    = valid_q;
    shift_en   = 1'b0;
    shift_word = '0;

    case (state_q)
      ST_LOAD: begin
        if (in_hs) begin
          out_d      = data_in;
          id_d       = t_q;
          last_d     = 1'b0;
          valid_d    = 1'b1;
          shift_en   = 1'b1;
          shift_word = data_in;
          t_d        = t_q + 6'd1;
          if (t_q == 6'd15) begin
            state_d = ST_EXPAND;
          end
        end else if (out_free) begin
          valid_d = 1'b0;
        end
      end
      ST_EXPAND: begin
        if (out_free) begin
          out_d      = expand_word;
          id_d       = t_q;
          last_d     = (t_q == 6'd63);
          valid_d    = 1'b1;
          shift_en   = 1'b1;
          shift_word = expand_word;
          // The counter returns to 0 only here, after W[63] is issued.
          if (t_q == 6'd63) begin
            t_d     = 6'd0;
            state_d = ST_LOAD;
          end else begin
            t_d = t_q + 6'd1;
          end
        end
      end
      default: begin
        state_d = ST_LOAD;
        t_d     = 6'd0;
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      win_d[i] = win_q[i];
    end
    if (shift_en) begin
      for (int i = 0; i < 15; i++) begin
        win_d[i] = win_q[i+1];
      end
      win_d[15] = shift_word;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_LOAD;
      t_q     <= 6'd0;
      out_q   <= '0;
      id_q    <= 6'd0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      out_q   <= out_d;
      id_q    <= id_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  assign data_out       = out_q;
  assign data_out_id    = id_q;
  assign data_out_last  = last_q;
  assign data_out_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sha_2_message_schedule.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha_2_message_schedule
// Purpose  : Self-checking bench for sha_2_message_schedule. Expected schedule
//            words are pushed to a scoreboard queue as input words are
//            accepted and popped on every output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha_2_message_schedule;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] data_in;
  logic        data_in_valid;
  logic        data_in_ready;
  logic [31:0] data_out;
  logic [5:0]  data_out_id;
  logic        data_out_last;
  logic        data_out_valid;
  logic        data_out_ready;

  always #5 clk = ~clk;

  sha_2_message_schedule #(.DATA_WIDTH(32)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_id    (data_out_id),
    .data_out_last  (data_out_last),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [5:0]  id;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] in_words[$];
  int          in_idx;
  logic [31:0] obs_data [64];
  int          tests;
  int          fails;
  int          expand_in_hs;     // inputs consumed while DUT is expanding
  int          expand_blocked;   // output handshakes with valid input refused

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_rotr(input logic [31:0] x, input int n);
    logic [63:0] dbl;
    dbl = {x, x} >> n;
    return dbl[31:0];
  endfunction

  function automatic logic [31:0] m_s0(input logic [31:0] x);
    return m_rotr(x, 7) ^ m_rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] m_s1(input logic [31:0] x);
    return m_rotr(x, 17) ^ m_rotr(x, 19) ^ (x >> 10);
  endfunction

  // Push W[16..63] of the block whose first word sits at in_words[base].
  task automatic push_expanded(input int base);
    logic [31:0] w [64];
    exp_t e;
    for (int i = 0; i < 16; i++) w[i] = in_words[base + i];
    for (int i = 16; i < 64; i++) begin
      w[i] = m_s1(w[i-2]) + w[i-7] + m_s0(w[i-15]) + w[i-16];
      e.d    = w[i];
      e.id   = 6'(i);
      e.last = (i == 63);
      sb.push_back(e);
    end
  endtask

  task automatic load_abc();
    in_words.push_back(32'h61626380);
    for (int i = 1; i < 15; i++) in_words.push_back(32'h0);
    in_words.push_back(32'h00000018);
  endtask

  task automatic load_zero();
    for (int i = 0; i < 16; i++) in_words.push_back(32'h0);
  endtask

  // Drive in_words, check every output handshake against the scoreboard.
  // stop_id >= 0 returns early once that id is sitting in the output register.
  task automatic run(input bit rand_ready, input bit gaps, input int stop_id,
                     input int max_cycles, output int cycles);
    int          n_out;
    int          n_exp;
    bit          stalled;
    logic [31:0] s_d;
    logic [5:0]  s_id;
    logic        s_last;
    exp_t        e;
    n_out   = 0;
    n_exp   = in_words.size() * 4;
    stalled = 1'b0;
    in_idx  = 0;
    cycles  = 0;
    s_d = '0; s_id = '0; s_last = 1'b0;
    while (!(n_out == n_exp && in_idx == in_words.size())) begin
      if (cycles >= max_cycles) begin
        tests++;
        fails++;
        $display("FAIL timeout: %0d outputs after %0d cycles, required %0d", n_out, cycles, n_exp);
        break;
      end
      @(negedge clk);
      data_in_valid  = (in_idx < in_words.size()) && (!gaps || $urandom_range(0, 2) != 0);
      data_in        = data_in_valid ? in_words[in_idx] : $urandom;
      data_out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      cycles++;
      if (stop_id >= 0 && data_out_valid && int'(data_out_id) == stop_id) break;
      if (stalled) begin
        tests++;
        if ({data_out_valid, data_out, data_out_id, data_out_last} !== {1'b1, s_d, s_id, s_last}) begin
          fails++;
          $display("FAIL stall_hold: got v=%b %h id=%0d last=%b, required v=1 %h id=%0d last=%b",
                   data_out_valid, data_out, data_out_id, data_out_last, s_d, s_id, s_last);
        end
      end
      if (data_out_valid && data_out_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL extra_output: got id=%0d %h, required no output", data_out_id, data_out);
        end else begin
          e = sb.pop_front();
          if ({data_out, data_out_id, data_out_last} !== {e.d, e.id, e.last}) begin
            fails++;
            $display("FAIL word: got %h id=%0d last=%b, required %h id=%0d last=%b",
                     data_out, data_out_id, data_out_last, e.d, e.id, e.last);
          end
        end
        obs_data[data_out_id] = data_out;
        n_out++;
      end
      // Output register holds an id in 15..62 only while expanding.
      if (data_out_valid && data_out_id >= 6'd15 && data_out_id <= 6'd62) begin
        if (data_in_valid && data_in_ready) expand_in_hs++;
        if (data_in_valid && !data_in_ready && data_out_ready) expand_blocked++;
      end
      stalled = data_out_valid && !data_out_ready;
      s_d = data_out; s_id = data_out_id; s_last = data_out_last;
      if (data_in_valid && data_in_ready) begin
        e.d    = in_words[in_idx];
        e.id   = 6'(in_idx % 16);
        e.last = 1'b0;
        sb.push_back(e);
        if (in_idx % 16 == 15) push_expanded(in_idx - 15);
        in_idx++;
      end
    end
    @(negedge clk);
    data_in_valid  = 1'b0;
    data_out_ready = 1'b1;
  endtask

  task automatic check_drained(input string name);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s_left: got %0d pending words, required 0", name, sb.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nrst = 1'b0; data_in = '0; data_in_valid = 1'b0; data_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk); #1;
    tests++;
    if ({data_out_valid, data_out, data_out_id, data_out_last} !== 40'h0) begin
      fails++;
      $display("FAIL reset_out: got v=%b %h id=%0d last=%b, required all 0",
               data_out_valid, data_out, data_out_id, data_out_last);
    end
    tests++;
    if (data_in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b, required 1", data_in_ready);
    end
  endtask

  task automatic test_abc();
    int cyc;
    in_words.delete(); sb.delete();
    load_abc();
    run(1'b0, 1'b0, -1, 500, cyc);
    check_drained("abc");
    tests++;
    if (cyc != 65) begin
      fails++;
      $display("FAIL abc_cycles: got %0d, required 65", cyc);
    end
    tests++;
    if (obs_data[16] !== 32'h61626380) begin
      fails++; $display("FAIL abc_w16: got %h, required 61626380", obs_data[16]);
    end
    tests++;
    if (obs_data[17] !== 32'h000F0000) begin
      fails++; $display("FAIL abc_w17: got %h, required 000f0000", obs_data[17]);
    end
    tests++;
    if (obs_data[18] !== 32'h7DA86405) begin
      fails++; $display("FAIL abc_w18: got %h, required 7da86405", obs_data[18]);
    end
  endtask

  task automatic test_stall();
    int cyc;
    in_words.delete(); sb.delete();
    load_abc();
    run(1'b1, 1'b1, -1, 2000, cyc);
    check_drained("stall");
  endtask

  task automatic test_back_to_back();
    int cyc;
    in_words.delete(); sb.delete();
    load_abc();
    load_zero();
    run(1'b0, 1'b0, -1, 1000, cyc);
    check_drained("b2b");
    tests++;
    if (cyc != 129) begin
      fails++;
      $display("FAIL b2b_cycles: got %0d, required 129", cyc);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    in_words.delete(); sb.delete();
    load_abc();
    run(1'b0, 1'b0, 30, 500, cyc);
    nrst = 1'b0;
    #1;
    tests++;
    if ({data_out_valid, data_out, data_out_id, data_out_last} !== 40'h0) begin
      fails++;
      $display("FAIL midreset_out: got v=%b %h id=%0d last=%b, required all 0",
               data_out_valid, data_out, data_out_id, data_out_last);
    end
    tests++;
    if (data_in_ready !== 1'b1) begin
      fails++;
      $display("FAIL midreset_ready: got %b, required 1", data_in_ready);
    end
    @(negedge clk);
    nrst = 1'b1;
    in_words.delete(); sb.delete();
    load_abc();
    run(1'b0, 1'b0, -1, 500, cyc);
    check_drained("midreset");
    tests++;
    if (cyc != 65) begin
      fails++;
      $display("FAIL midreset_cycles: got %0d, required 65", cyc);
    end
  endtask

  task automatic test_expand_ignore();
    int cyc;
    in_words.delete(); sb.delete();
    load_abc();
    load_zero();
    expand_in_hs   = 0;
    expand_blocked = 0;
    run(1'b0, 1'b0, -1, 1000, cyc);
    check_drained("expand");
    tests++;
    if (expand_in_hs != 0) begin
      fails++;
      $display("FAIL expand_consumed: got %0d inputs, required 0", expand_in_hs);
    end
    tests++;
    if (expand_blocked != 48) begin
      fails++;
      $display("FAIL expand_blocked: got %0d, required 48", expand_blocked);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    expand_in_hs = 0;
    expand_blocked = 0;
    for (int i = 0; i < 64; i++) obs_data[i] = 'x;
    test_reset();
    test_abc();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_expand_ignore();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sha_2_message_schedule.md
Name: sha_2_message_schedule

Overview:
- Generates the SHA-256 message schedule W[0..63] for one 512-bit block.
- Sits between the block/padding front end (upstream) and the compression round engine (downstream).
- Accepts the 16 block words as a valid/ready word stream and passes them through as W[0..15].
- Then computes W[16..63] from a 16-word sliding window and emits each word with its index, one per handshake.

Parameters:
- data_width, 32, word width in bits; only 32 (SHA-256) is supported.

Ports:
- clk  input  1  clock; all state updates on rising edge
- nrst  input  1  asynchronous active-low reset
- data_in  input  32  message word M[t], t = 0..15, big-endian word order
- data_in_valid  input  1  data_in holds a valid word
- data_in_ready  output  1  block will accept data_in this cycle
- data_out  output  32  schedule word W[t]
- data_out_id  output  6  index t of data_out (0..63)
- data_out_last  output  1  high with W[63]
- data_out_valid  output  1  data_out, data_out_id and data_out_last are valid
- data_out_ready  input  1  downstream accepts data_out this cycle

Behaviour:
- Reset (nrst low, asynchronous):
  - data_out, data_out_id, data_out_last, data_out_valid = 0.
  - Word counter t = 0, state = LOAD, all window registers = 0.
  - data_in_ready = 1 after reset because the output register is empty.
- Reset asserted mid-block aborts the block. After release the next accepted word is treated as W[0].
- Output register:
  - Single-entry, registered outputs.
  - Accepting a new word is allowed when out_free = !data_out_valid || data_out_ready.
  - While data_out_valid=1 and data_out_ready=0, all outputs hold stable.
- Handshakes: an input handshake occurs when data_in_valid && data_in_ready; an output handshake when data_out_valid && data_out_ready.
- Window: registers win[0..15] hold W[t-16]..W[t-1]. Each produced word shifts the window: win[i] <= win[i+1], win[15] <= new word.
- LOAD state (t = 0..15):
  - data_in_ready = out_free.
  - On input handshake:
    - data_out <= data_in, data_out_id <= t, data_out_valid <= 1, data_out_last <= 0.
    - Shift data_in into the window; t <= t+1.
    - If t = 15, go to EXPAND.
  - If out_free and no input handshake: data_out_valid <= 0.
- EXPAND state (t = 16..63):
  - data_in_ready = 0.
  - When out_free:
    - data_out <= ssig1(win[14]) + win[9] + ssig0(win[1]) + win[0], addition mod 2^32 (carries discarded).
    - data_out_id <= t, data_out_valid <= 1, data_out_last <= (t == 63).
    - Shift the window; t <= t+1.
  - Issuing W[63] sets t <= 0 and returns to LOAD.
- Functions (FIPS 180-4):
  - ssig0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x)
  - ssig1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x)
  - ROTR is a 32-bit rotate; SHR is a logical shift.
- Throughput and latency:
  - One word per cycle with data_out_ready held high.
  - Input-to-output latency is 1 cycle.
  - A full block is 64 output handshakes: 16 in LOAD, then 48 in EXPAND.
  - The first word of the next block can be accepted in the cycle after W[63] is issued.
- Boundary conditions:
  - data_in_valid is ignored in EXPAND.
  - data_out_ready has no effect while data_out_valid=0.
  - Simultaneous output handshake and new input/generation in the same cycle: the register reloads and data_out_valid stays 1 (no bubble).
  - t never exceeds 63; the 6-bit counter wraps to 0 only via the explicit return to LOAD.
- Two-block message: the window carries no state between blocks; each block's W[16..] depends only on its own 16 words.

Test Plan:
- Reset release, idle -> all outputs 0, data_in_ready=1, data_out_valid=0.
- "abc" padded block, ready held high: W0=0x61626380, W1..W14=0, W15=0x00000018 -> W[0..15] echoed with ids 0..15; W16=0x61626380, W17=0x000F0000, W18=0x7DA86405; 64 outputs total, data_out_last only on id 63.
- Same block with data_out_ready toggled pseudo-randomly and data_in_valid gapped -> identical W sequence; outputs stable while stalled; no drops or duplicates.
- Two back-to-back blocks ("abc", then all-zero block) -> second block accepted the cycle after W[63]; all-zero block yields W[0..63]=0.
- nrst pulsed during EXPAND at id 30 -> outputs clear immediately; after release, a fresh "abc" block yields a correct full schedule from id 0.
- data_in_valid held high throughout EXPAND -> data_in_ready=0 for 48 output handshakes; no input consumed until LOAD resumes.
